// File: rtl/harvos_ram_arbiter.sv
// ---------------------------------------------------------------------------
// harvos_ram_arbiter
//   Shares the single-port SoC RAM between N_REQ requesters
//   (0 = I-side, 1 = D-side, 2 = DMA firewall). One transaction is in flight
//   at a time: the winner's command is registered and issued to the RAM as a
//   one-cycle request. The response is routed back to the owner only. A
//   watchdog timer turns a silent RAM into a fault response.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   rq_req/we         per-requester request level and write enable
//   rq_be/addr/wdata  per-requester command slices (4/32/32 bits each)
//   rsp_valid         one-hot completion pulse to the owner
//   rsp_fault         qualifies rsp_valid (RAM fault or timeout)
//   rsp_rdata         read data of the last read completion
//   m_req..m_wdata    registered command towards the RAM
//   m_rdata/rvalid/fault  RAM completion
//   busy              arbiter is not idle
//   owner             current or last granted requester index
//   to_err            one-cycle pulse when the timeout fires
// ---------------------------------------------------------------------------
module harvos_ram_arbiter #(
  parameter int N_REQ   = 3,
  parameter int ARB_RR  = 1,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      rq_req,
  input  logic [N_REQ-1:0]      rq_we,
  input  logic [4*N_REQ-1:0]    rq_be,
  input  logic [32*N_REQ-1:0]   rq_addr,
  input  logic [32*N_REQ-1:0]   rq_wdata,
  output logic [N_REQ-1:0]      rsp_valid,
  output logic                  rsp_fault,
  output logic [31:0]           rsp_rdata,
  output logic                  m_req,
  output logic                  m_we,
  output logic [3:0]            m_be,
  output logic [31:0]           m_addr,
  output logic [31:0]           m_wdata,
  input  logic [31:0]           m_rdata,
  input  logic                  m_rvalid,
  input  logic                  m_fault,
  output logic                  busy,
  output logic [2:0]            owner,
  output logic                  to_err
);

  // The timer only has to reach TIMEOUT-1.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [2:0]      r_rr_ptr;
  logic [TW-1:0]   r_timer;

  logic [2:0]      w_win;
  int              w_base;
  logic            w_we;
  logic [3:0]      w_be;
  logic [31:0]     w_addr;
  logic [31:0]     w_wdata;
  logic            w_timeout;

  // Winner selection. Round-robin starts at r_rr_ptr. The first pass scans
  // from the pointer up to the top index. The second pass wraps around to
  // the indices below the pointer. In fixed mode the base is 0, so only the
  // first pass can hit.
  always_comb begin
    w_win  = 3'd0;
    w_base = (ARB_RR != 0) ? int'(r_rr_ptr) : 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rq_req[i] && (i < w_base)) w_win = 3'(i);
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rq_req[i] && (i >= w_base)) w_win = 3'(i);
    end
  end

  // Pick out the winner's command slices.
  always_comb begin
    w_we    = 1'b0;
    w_be    = 4'd0;
    w_addr  = 32'd0;
    w_wdata = 32'd0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_win == 3'(i)) begin
        w_we    = rq_we[i];
        w_be    = rq_be[4*i +: 4];
        w_addr  = rq_addr[32*i +: 32];
        w_wdata = rq_wdata[32*i +: 32];
      end
    end
  end

  assign w_timeout = (TIMEOUT != 0) && (r_timer == TW'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (|rq_req) w_next = ST_ISSUE;
      ST_ISSUE: w_next = ST_WAIT;
      ST_WAIT:  if (m_rvalid || w_timeout) w_next = ST_RESP;
      ST_RESP:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Registered outputs. Each one is updated on the edge that enters the
  // state where it must be visible. This keeps every output a flop without
  // adding a cycle of latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr  <= 3'd0;
      r_timer   <= '0;
      rsp_valid <= '0;
      rsp_fault <= 1'b0;
      rsp_rdata <= 32'd0;
      m_req     <= 1'b0;
      m_we      <= 1'b0;
      m_be      <= 4'd0;
      m_addr    <= 32'd0;
      m_wdata   <= 32'd0;
      busy      <= 1'b0;
      owner     <= 3'd0;
      to_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|rq_req) begin
            m_req    <= 1'b1;
            m_we     <= w_we;
            m_be     <= w_be;
            m_addr   <= w_addr;
            m_wdata  <= w_wdata;
            owner    <= w_win;
            busy     <= 1'b1;
            r_rr_ptr <= (w_win == 3'(N_REQ - 1)) ? 3'd0 : w_win + 3'd1;
          end
        end
        ST_ISSUE: begin
          m_req   <= 1'b0;
          r_timer <= '0;
        end
        ST_WAIT: begin
          r_timer <= r_timer + TW'(1);
          // A real completion wins over a timeout in the same cycle.
          if (m_rvalid) begin
            if (!m_we) rsp_rdata <= m_rdata;
            rsp_fault <= m_fault;
            rsp_valid <= N_REQ'(1) << owner;
          end else if (w_timeout) begin
            rsp_fault <= 1'b1;
            rsp_valid <= N_REQ'(1) << owner;
            to_err    <= 1'b1;
          end
        end
        ST_RESP: begin
          rsp_valid <= '0;
          rsp_fault <= 1'b0;
          to_err    <= 1'b0;
          m_we      <= 1'b0;
          m_be      <= 4'd0;
          m_addr    <= 32'd0;
          m_wdata   <= 32'd0;
          busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
